add_share_arb: RTL and testbench



---
 rtl/add_share_arb.sv | 120 ++++++++++++
 tb/tb_add_share_arb.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/add_share_arb.sv
// add_share_arb: round-robin arbiter in front of one shared registered adder.
// NREQ requesters compete for a single-entry result slot. The grant is
// combinational, and the sum appears one cycle after acceptance, tagged with
// the ID of the requester that produced it.

// Per-requester window bit: marks a valid requester whose index is above
// the last winner, i.e. one that lies in the "after last" half of the
// rotation.
module add_share_arb_lane #(
    parameter int IDW = 2,
    parameter int IDX = 0
) (
    input  logic [IDW-1:0] last,
    input  logic           valid,
    output logic           hi
);
    localparam logic [IDW-1:0] IDX_W = IDW'(IDX);

    // Requester sits strictly after the previous winner in rotation order
    assign hi = valid && (IDX_W > last);
endmodule

module add_share_arb #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [IDW-1:0]          res_id,
    output logic [WIDTH:0]          res_sum
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [WIDTH:0] sum;
    } res_t;

    state_t          state_q, state_d;
    res_t            res_q;
    logic [IDW-1:0]  last_q;
    logic [NREQ-1:0] hi_vld;
    logic [IDW-1:0]  lo_idx, hi_idx, gnt_idx;
    logic            lo_any, hi_any;
    logic            slot_free, accept;
    logic [WIDTH-1:0] a_sel, b_sel;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        add_share_arb_lane #(.IDW(IDW), .IDX(i)) u_lane (
            .last  (last_q),
            .valid (req_valid[i]),
            .hi    (hi_vld[i])
        );
    end

    // The slot can take a new result when it is empty or is being drained now
    assign slot_free = (state_q == EMPTY) || res_ready;

    // Lowest-index winner in both the after-last window and the full vector;
    // the window wins when non-empty, which gives the wrap-around search.
    always_comb begin
        lo_idx = '0;
        lo_any = 1'b0;
        hi_idx = '0;
        hi_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = IDW'(i);
                lo_any = 1'b1;
            end
            if (hi_vld[i]) begin
                hi_idx = IDW'(i);
                hi_any = 1'b1;
            end
        end
    end

    assign gnt_idx   = hi_any ? hi_idx : lo_idx;
    assign accept    = lo_any && slot_free && !rst;
    assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;
    assign a_sel     = req_a[gnt_idx*WIDTH +: WIDTH];
    assign b_sel     = req_b[gnt_idx*WIDTH +: WIDTH];

    // Slot occupancy: fill on accept, empty on a drain with no refill
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (res_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // State, result slot and rotation pointer; the pointer moves only on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            res_q   <= '0;
            last_q  <= IDW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            if (accept) begin
                res_q.sum <= {1'b0, a_sel} + {1'b0, b_sel};
                res_q.id  <= gnt_idx;
                last_q    <= gnt_idx;
            end
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_id    = res_q.id;
    assign res_sum   = res_q.sum;
endmodule

// File: tb/tb_add_share_arb.sv
// Directed bench for add_share_arb (NREQ=4, WIDTH=8). Each table row drives
// one cycle: req_ready is compared before the edge, and the result
// outputs are compared after it.
module tb_add_share_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [8:0]  res_sum;

    int checks = 0;
    int errors = 0;

    add_share_arb #(.NREQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [31:0] a;
        logic [31:0] b;
        logic        rr;
        logic [3:0]  e_ready;
        logic        e_rv;
        logic [1:0]  e_id;
        logic [8:0]  e_sum;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] a, logic [31:0] b,
                                logic rr, logic [3:0] er, logic erv, logic [1:0] eid,
                                logic [8:0] es);
        vec_t t;
        t.rst = r; t.vld = v; t.a = a; t.b = b; t.rr = rr;
        t.e_ready = er; t.e_rv = erv; t.e_id = eid; t.e_sum = es;
        return t;
    endfunction

    task automatic chk(string name, int step, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, got, exp);
        end
    endtask

    localparam logic [31:0] RR_A = 32'h281E140A;  // lanes 3..0: 40,30,20,10
    localparam logic [31:0] RR_B = 32'h04030201;  // lanes 3..0: 4,3,2,1
    localparam logic [31:0] L3A0A = 32'h07000005; // lane3 a=7, lane0 a=5
    localparam logic [31:0] L3B0B = 32'h09000006; // lane3 b=9, lane0 b=6

    initial begin
        int wait_cyc;
        bit got_gnt;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;

        // reset with every requester asking
        vq.push_back(mk(1, 4'hF, RR_A, RR_B, 1, 4'b0000, 0, 0, 9'd0));
        vq.push_back(mk(1, 4'hF, RR_A, RR_B, 1, 4'b0000, 0, 0, 9'd0));
        // single request from requester 2: 100+27
        vq.push_back(mk(0, 4'b0100, 32'h00640000, 32'h001B0000, 1, 4'b0100, 1, 2, 9'd127));
        // idle cycle drains the slot, fields hold
        vq.push_back(mk(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 2, 9'd127));
        // reset then round-robin 0,1,2,3,0,1 with no bubbles
        vq.push_back(mk(1, 4'hF, RR_A, RR_B, 1, 4'b0000, 0, 0, 9'd0));
        vq.push_back(mk(0, 4'hF, RR_A, RR_B, 1, 4'b0001, 1, 0, 9'd11));
        vq.push_back(mk(0, 4'hF, RR_A, RR_B, 1, 4'b0010, 1, 1, 9'd22));
        vq.push_back(mk(0, 4'hF, RR_A, RR_B, 1, 4'b0100, 1, 2, 9'd33));
        vq.push_back(mk(0, 4'hF, RR_A, RR_B, 1, 4'b1000, 1, 3, 9'd44));
        vq.push_back(mk(0, 4'hF, RR_A, RR_B, 1, 4'b0001, 1, 0, 9'd11));
        vq.push_back(mk(0, 4'hF, RR_A, RR_B, 1, 4'b0010, 1, 1, 9'd22));
        // carry cases
        vq.push_back(mk(0, 4'b0001, 32'h000000FF, 32'h000000FF, 1, 4'b0001, 1, 0, 9'h1FE));
        vq.push_back(mk(0, 4'b0010, 32'h00008000, 32'h00008000, 1, 4'b0010, 1, 1, 9'h100));
        // fill slot with id1 sum5, then stall 5 cycles with requester 3 waiting
        vq.push_back(mk(0, 4'b0010, 32'h00000200, 32'h00000300, 1, 4'b0010, 1, 1, 9'd5));
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(0, 4'b1000, L3A0A, L3B0B, 0, 4'b0000, 1, 1, 9'd5));
        vq.push_back(mk(0, 4'b1000, L3A0A, L3B0B, 1, 4'b1000, 1, 3, 9'd16));
        // withdrawn request, stalled slot holds
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 1, 3, 9'd16));
        // last=2, then reset pulse; first grant after reset goes to 0, not 3
        vq.push_back(mk(0, 4'b0100, 32'h00010000, 32'h00010000, 1, 4'b0100, 1, 2, 9'd2));
        vq.push_back(mk(1, 4'b1001, L3A0A, L3B0B, 0, 4'b0000, 0, 0, 9'd0));
        vq.push_back(mk(0, 4'b1001, L3A0A, L3B0B, 1, 4'b0001, 1, 0, 9'd11));
        vq.push_back(mk(0, 4'b1001, L3A0A, L3B0B, 1, 4'b1000, 1, 3, 9'd16));
        // lone requester 0 wins every free cycle, wrapping past last
        vq.push_back(mk(0, 4'b0001, L3A0A, L3B0B, 1, 4'b0001, 1, 0, 9'd11));
        vq.push_back(mk(0, 4'b0001, L3A0A, L3B0B, 1, 4'b0001, 1, 0, 9'd11));

        foreach (vq[k]) begin
            @(negedge clk);
            rst = vq[k].rst; req_valid = vq[k].vld; req_a = vq[k].a;
            req_b = vq[k].b; res_ready = vq[k].rr;
            #1;
            chk("req_ready", k, 32'(req_ready), 32'(vq[k].e_ready));
            @(posedge clk);
            #1;
            chk("res_valid", k, 32'(res_valid), 32'(vq[k].e_rv));
            chk("res_id", k, 32'(res_id), 32'(vq[k].e_id));
            chk("res_sum", k, 32'(res_sum), 32'(vq[k].e_sum));
        end

        // Fairness: from reset with all four asking, requester 2 is reached on
        // the third accept (cycle index 2), bounded by an 8-cycle budget.
        @(negedge clk);
        rst = 1'b1; req_valid = 4'hF; res_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_cyc = 0;
        got_gnt = 1'b0;
        for (int c = 0; c < 8 && !got_gnt; c++) begin
            #1;
            if (req_ready[2]) begin
                got_gnt = 1'b1;
                wait_cyc = c;
            end else begin
                @(negedge clk);
            end
        end
        chk("fair_granted", 0, 32'(got_gnt), 32'd1);
        chk("fair_cycle", 0, 32'(wait_cyc), 32'd2);

        // Reset asserted while the slot is full and requests pending: no grant
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_no_grant", 0, 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_clears_valid", 0, 32'(res_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
